// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the branch resolution logic: funct3 and
// opcode encodings, the resolve FSM state type, and the taken decode.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // Reserved branch encodings 010/011 never redirect.
    function automatic logic funct3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // Branch condition from the comparator flags; reserved encodings fall out as not taken.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt_s,
                                          input logic       lt_u);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Purely combinational operand comparator for branch resolution.
// eq and the lt flags are mutually exclusive by construction.
module branch_cmp_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution controller: static not-taken policy,
// one-cycle redirect pulse on a taken branch, multi-cycle IF/ID + ID/EX
// flush that freezes under stall, and saturating branch statistics.
module branch_resolve_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1_val,
    input  logic [XLEN-1:0]  ex_rs2_val,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             stall_i,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic             br_illegal,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int              FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    br_state_e        state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             br_illegal_q, br_illegal_d;
    logic [CNT_W-1:0] cnt_branches_q, cnt_branches_d;
    logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

    logic eq, lt_s, lt_u;
    logic accept, illegal, taken;

    branch_cmp_core #(.XLEN(XLEN)) u_cmp (
        .rs1  (ex_rs1_val),
        .rs2  (ex_rs2_val),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    // Branches are only evaluated in IDLE; anything seen during FLUSH is wrong-path.
    assign accept  = ex_valid & ex_is_branch & ~stall_i & (state_q == IDLE);
    assign illegal = funct3_illegal(ex_funct3);
    assign taken   = branch_taken(ex_funct3, eq, lt_s, lt_u);

    // Next-state logic: start the flush on a taken branch, count it down while not stalled.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (accept && taken) begin
                    state_d          = FLUSH;
                    fcnt_d           = FC_LOAD;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ex_target;
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    if (fcnt_q == FC_ONE) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - FC_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // Illegal-encoding pulse and saturating statistics counters.
    always_comb begin
        br_illegal_d   = accept & illegal;
        cnt_branches_d = cnt_branches_q;
        cnt_taken_d    = cnt_taken_q;
        if (accept && (cnt_branches_q != '1)) begin
            cnt_branches_d = cnt_branches_q + CNT_W'(1);
        end
        if (accept && taken && (cnt_taken_q != '1)) begin
            cnt_taken_d = cnt_taken_q + CNT_W'(1);
        end
    end

    // State registers; reset aborts any flush in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_illegal_q     <= 1'b0;
            cnt_branches_q   <= '0;
            cnt_taken_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_illegal_q     <= br_illegal_d;
            cnt_branches_q   <= cnt_branches_d;
            cnt_taken_q      <= cnt_taken_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = (state_q == FLUSH);
    assign flush_id_ex    = (state_q == FLUSH);
    assign busy           = (state_q == FLUSH);
    assign br_illegal     = br_illegal_q;
    assign cnt_branches   = cnt_branches_q;
    assign cnt_taken      = cnt_taken_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: stimulus pushes expected
// redirect / illegal events, a negedge monitor pops and compares them and
// measures every flush run length. Small counters make saturation reachable.
module tb_branch_resolve_ctrl;
    import riscv_pkg::*;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid, ex_is_branch, stall_i;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_rs1_val, ex_rs2_val, ex_target;
    logic             redirect_valid, flush_if_id, flush_id_ex, busy, br_illegal;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] cnt_branches, cnt_taken;

    typedef struct {
        logic             ill;
        logic [31:0]      pc;
        logic [CNT_W-1:0] cb;
        logic [CNT_W-1:0] ct;
        int               flen;
    } exp_t;

    exp_t             exp_q[$];
    int               flen_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               run_len = 0;
    logic [CNT_W-1:0] m_cb = '0;
    logic [CNT_W-1:0] m_ct = '0;

    branch_resolve_ctrl #(
        .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_target(ex_target),
        .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy(busy),
        .br_illegal(br_illegal), .cnt_branches(cnt_branches), .cnt_taken(cnt_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    task automatic expect_taken(input logic [31:0] pc, input int flen);
        m_cb = sat_inc(m_cb);
        m_ct = sat_inc(m_ct);
        exp_q.push_back('{1'b0, pc, m_cb, m_ct, flen});
    endtask

    task automatic expect_not_taken();
        m_cb = sat_inc(m_cb);
    endtask

    task automatic expect_illegal();
        m_cb = sat_inc(m_cb);
        exp_q.push_back('{1'b1, 32'h0, m_cb, m_ct, 0});
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] t, input int hold);
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_funct3    = f3;
        ex_rs1_val   = a;
        ex_rs2_val   = b;
        ex_target    = t;
        repeat (hold) @(posedge clk);
        #1;
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt_branches"}, cnt_branches, m_cb);
        check({tag, "_cnt_taken"}, cnt_taken, m_ct);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_redirect_valid"}, redirect_valid, 1'b0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        check({tag, "_flush_if_id"}, flush_if_id, 1'b0);
        check({tag, "_flush_id_ex"}, flush_id_ex, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_br_illegal"}, br_illegal, 1'b0);
        check({tag, "_cnt_branches"}, cnt_branches, 0);
        check({tag, "_cnt_taken"}, cnt_taken, 0);
    endtask

    // Monitor: pop an expected event whenever the DUT pulses, and time every flush run.
    always @(negedge clk) begin
        exp_t e;
        int   fl;
        if (!rst_n) begin
            run_len = 0;
            flen_q.delete();
        end else begin
            check("flush_if_id_vs_busy", flush_if_id, busy);
            check("flush_id_ex_vs_busy", flush_id_ex, busy);
            if (redirect_valid || br_illegal) begin
                check("event_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("event_br_illegal", br_illegal, e.ill);
                    check("event_redirect_valid", redirect_valid, !e.ill);
                    check("event_cnt_branches", cnt_branches, e.cb);
                    check("event_cnt_taken", cnt_taken, e.ct);
                    if (!e.ill) begin
                        check("redirect_pc", redirect_pc, e.pc);
                        flen_q.push_back(e.flen);
                    end
                end
            end
            if (busy) begin
                run_len++;
            end else if (run_len != 0) begin
                check("flush_run_expected", flen_q.size() != 0, 1'b1);
                if (flen_q.size() != 0) begin
                    fl = flen_q.pop_front();
                    check("flush_len", run_len, fl);
                end
                run_len = 0;
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        stall_i      = 1'b0;
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_funct3    = 3'b000;
        ex_rs1_val   = '0;
        ex_rs2_val   = '0;
        ex_target    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        // BEQ equal operands: taken, 2-cycle flush
        expect_taken(32'h100, 2);
        drive(F3_BEQ, 32'h10, 32'h10, 32'h100, 1);
        idle(3);
        check_counts("beq");

        // Signed vs unsigned on -1 vs 1
        expect_taken(32'h200, 2);
        drive(F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h200, 1);
        idle(3);
        expect_not_taken();
        drive(F3_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h300, 1);
        idle(1);
        check_counts("bltu");

        // Equality boundaries and signed/unsigned extremes
        expect_taken(32'h310, 2);
        drive(F3_BGEU, 32'h5, 32'h5, 32'h310, 1);
        idle(3);
        expect_not_taken();
        drive(F3_BLT, 32'h5, 32'h5, 32'h314, 1);
        idle(1);
        expect_not_taken();
        drive(F3_BNE, 32'h9, 32'h9, 32'h318, 1);
        idle(1);
        expect_not_taken();
        drive(F3_BGE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h31C, 1);
        idle(1);
        expect_taken(32'h320, 2);
        drive(F3_BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h320, 1);
        idle(3);
        check_counts("bounds");

        // Wrong-path branches during FLUSH squashed; next one accepted once busy drops
        expect_taken(32'h400, 2);
        expect_taken(32'h500, 2);
        drive(F3_BNE, 32'h1, 32'h2, 32'h400, 1);
        drive(F3_BEQ, 32'h7, 32'h7, 32'h500, 3);
        idle(3);
        check_counts("squash");

        // Stall in IDLE blocks acceptance until it falls
        stall_i      = 1'b1;
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_funct3    = F3_BEQ;
        ex_rs1_val   = 32'h2;
        ex_rs2_val   = 32'h2;
        ex_target    = 32'h600;
        idle(2);
        check("stall_idle_busy", busy, 1'b0);
        check("stall_idle_cnt_branches", cnt_branches, m_cb);
        expect_taken(32'h600, 2);
        stall_i = 1'b0;
        idle(1);
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        idle(3);
        check_counts("stall_idle");

        // Stall for 3 cycles from N+1 stretches the flush to 5 cycles
        expect_taken(32'h700, 5);
        drive(F3_BGE, 32'h3, 32'h3, 32'h700, 1);
        stall_i = 1'b1;
        idle(3);
        stall_i = 1'b0;
        idle(5);
        check_counts("stall_flush");

        // Reserved funct3 encodings and a non-branch instruction
        expect_illegal();
        drive(3'b010, 32'h4, 32'h4, 32'h800, 1);
        idle(1);
        expect_illegal();
        drive(3'b011, 32'h4, 32'h4, 32'h804, 1);
        idle(1);
        ex_valid   = 1'b1;
        ex_funct3  = F3_BEQ;
        ex_rs1_val = 32'h1;
        ex_rs2_val = 32'h1;
        ex_target  = 32'h808;
        idle(2);
        ex_valid = 1'b0;
        idle(1);
        check_counts("illegal");

        // Asynchronous reset in the middle of a flush
        expect_taken(32'h900, 2);
        drive(F3_BEQ, 32'h0, 32'h0, 32'h900, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_flush_reset");
        m_cb = '0;
        m_ct = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(3);
        check("post_reset_redirect", redirect_valid, 1'b0);
        check_counts("post_reset");

        // 20 taken branches saturate both counters at 15
        for (int i = 0; i < 20; i++) begin
            expect_taken(32'hA00 + 32'(i) * 4, 2);
            drive(F3_BEQ, 32'(i), 32'(i), 32'hA00 + 32'(i) * 4, 1);
            idle(2);
        end
        idle(3);
        check_counts("saturate");
        check("saturate_cnt_branches_15", cnt_branches, 4'd15);
        check("saturate_cnt_taken_15", cnt_taken, 4'd15);

        idle(2);
        check("events_drained", exp_q.size(), 0);
        check("flush_runs_drained", flen_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
